demux_collector: RTL and testbench



---
 rtl/demux_collector.sv | 138 +++++++++++++
 tb/tb_demux_collector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_collector.sv
// Four-channel serial-to-parallel collector behind a 1-to-4 demux, with a round-robin valid/ready word output.
// Optional define DEMUX_COLLECTOR_OVERFLOW_EN enables sticky per-channel overflow flags for dropped bits.
module demux_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic [1:0]       sel,
  input  logic             in0,
  input  logic             in1,
  input  logic             in2,
  input  logic             in3,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_data,
  output logic [1:0]       word_ch,
  output logic [3:0]       overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_sr  [4];
  logic [CW-1:0]    r_cnt [4];
  logic [1:0]       r_rr;
  logic             r_word_valid;
  logic [WIDTH-1:0] r_word_data;
  logic [1:0]       r_word_ch;

  logic       w_bit;
  logic [3:0] w_full;
  logic [3:0] w_cap;
  logic [3:0] w_unload;
  logic [3:0] w_drop;
  logic       w_free;
  logic       w_pick_valid;
  logic [1:0] w_pick;
  logic [1:0] w_idx;

  always_comb begin
    w_bit = 1'b0;
    case (sel)
      2'd0:    w_bit = in0;
      2'd1:    w_bit = in1;
      2'd2:    w_bit = in2;
      default: w_bit = in3;
    endcase
  end

  assign w_free = !r_word_valid || word_ready;

  // Round-robin search: walk from the highest offset down so the lowest offset from r_rr wins.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = r_rr;
    w_idx        = r_rr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_rr + 2'(k);
      if (w_full[w_idx]) begin
        w_pick_valid = 1'b1;
        w_pick       = w_idx;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_full[c]   = (r_cnt[c] == CW'(WIDTH));
      w_cap[c]    = bit_valid && (sel == 2'(c));
      w_unload[c] = w_free && w_pick_valid && (w_pick == 2'(c));
      w_drop[c]   = w_cap[c] && w_full[c] && !w_unload[c];
    end
  end

  // NOTE: the shift-register array is reset explicitly because partial words must read as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        r_sr[c]  <= '0;
        r_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (w_unload[c]) begin
          if (w_cap[c]) begin
            r_sr[c]  <= {w_bit, r_sr[c][WIDTH-1:1]};
            r_cnt[c] <= CW'(1);
          end else begin
            r_cnt[c] <= '0;
          end
        end else if (w_cap[c] && !w_full[c]) begin
          r_sr[c]  <= {w_bit, r_sr[c][WIDTH-1:1]};
          r_cnt[c] <= r_cnt[c] + CW'(1);
        end
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so the unload reads r_sr before this edge's shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr         <= 2'd0;
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_word_ch    <= 2'd0;
    end else if (w_free) begin
      r_word_valid <= w_pick_valid;
      if (w_pick_valid) begin
        r_word_data <= r_sr[w_pick];
        r_word_ch   <= w_pick;
        r_rr        <= w_pick + 2'd1;
      end
    end
  end

  assign word_valid = r_word_valid;
  assign word_data  = r_word_data;
  assign word_ch    = r_word_ch;

`ifdef DEMUX_COLLECTOR_OVERFLOW_EN
  logic [3:0] r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 4'b0000;
    end else begin
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign overflow = r_overflow;
`else
  logic w_unused_drop;
  assign w_unused_drop = ^w_drop;
  assign overflow      = 4'b0000;
`endif

endmodule

// File: tb/tb_demux_collector.sv
// Directed testbench for demux_collector (WIDTH=8) with hand-computed expected words.
// Overflow expectation follows DEMUX_COLLECTOR_OVERFLOW_EN.
module tb_demux_collector;

  localparam int W = 8;

`ifdef DEMUX_COLLECTOR_OVERFLOW_EN
  localparam logic [3:0] EXP_OVF = 4'b0001;
`else
  localparam logic [3:0] EXP_OVF = 4'b0000;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bit_valid = 1'b0;
  logic [1:0]   sel = 2'd0;
  logic         in0 = 1'b0, in1 = 1'b0, in2 = 1'b0, in3 = 1'b0;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_data;
  logic [1:0]   word_ch;
  logic [3:0]   overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]   ch;
    logic [W-1:0] data;
    int           cyc;
  } word_t;

  word_t q[$];

  demux_collector #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .sel(sel),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_ch(word_ch), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every handshake; inputs are stable at the falling edge, so this is what the next rising edge accepts.
  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) q.push_back('{word_ch, word_data, cyc});
  end

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic b, input logic other);
    sel = ch;
    in0 = (ch == 2'd0) ? b : other;
    in1 = (ch == 2'd1) ? b : other;
    in2 = (ch == 2'd2) ? b : other;
    in3 = (ch == 2'd3) ? b : other;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] ch, input logic [W-1:0] data);
    for (int i = 0; i < W; i++) send(ch, data[i], 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", word_valid); end
    checks++; if (word_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", word_data); end
    checks++; if (word_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", word_ch); end
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL reset_ovf got %b exp 0000", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    logic [7:0] bits;
    bits = 8'b0000_1101;
    word_ready = 1'b1;
    for (int i = 0; i < W; i++) send(2'd0, bits[i], 1'b0);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", word_valid); end
    idle(1);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", word_valid); end
    checks++; if (word_data !== 8'h0D) begin errors++; $display("FAIL single_data got %h exp 0d", word_data); end
    checks++; if (word_ch !== 2'd0) begin errors++; $display("FAIL single_ch got %0d exp 0", word_ch); end
    idle(1);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", word_valid); end
  endtask

  task automatic test_interleave;
    logic [W-1:0] exp_data [4];
    exp_data = '{8'h00, 8'h00, 8'hFF, 8'h00};
    word_ready = 1'b1;
    q.delete();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < 4; c++) send(2'(c), (c == 2), 1'b1);
    idle(3);
    checks++; if (q.size() !== 4) begin errors++; $display("FAIL interleave_count got %0d exp 4", q.size()); end
    if (q.size() == 4) begin
      for (int c = 0; c < 4; c++) begin
        checks++; if (q[c].ch !== 2'(c)) begin errors++; $display("FAIL interleave_ch%0d got %0d exp %0d", c, q[c].ch, c); end
        checks++; if (q[c].data !== exp_data[c]) begin errors++; $display("FAIL interleave_data%0d got %h exp %h", c, q[c].data, exp_data[c]); end
      end
    end
  endtask

  task automatic test_backpressure;
    word_ready = 1'b0;
    q.delete();
    send_word(2'd1, 8'hA5);
    send_word(2'd3, 8'h3C);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", word_valid); end
    checks++; if (word_ch !== 2'd1) begin errors++; $display("FAIL bp_ch got %0d exp 1", word_ch); end
    checks++; if (word_data !== 8'hA5) begin errors++; $display("FAIL bp_data got %h exp a5", word_data); end
    idle(2);
    checks++; if (word_ch !== 2'd1 || word_data !== 8'hA5) begin errors++; $display("FAIL bp_stable got %0d/%h exp 1/a5", word_ch, word_data); end
    word_ready = 1'b1;
    idle(3);
    checks++; if (q.size() !== 2) begin errors++; $display("FAIL bp_count got %0d exp 2", q.size()); end
    if (q.size() == 2) begin
      checks++; if (q[0].ch !== 2'd1 || q[0].data !== 8'hA5) begin errors++; $display("FAIL bp_first got %0d/%h exp 1/a5", q[0].ch, q[0].data); end
      checks++; if (q[1].ch !== 2'd3 || q[1].data !== 8'h3C) begin errors++; $display("FAIL bp_second got %0d/%h exp 3/3c", q[1].ch, q[1].data); end
      checks++; if (q[1].cyc !== q[0].cyc + 1) begin errors++; $display("FAIL bp_back_to_back got gap %0d exp 1", q[1].cyc - q[0].cyc); end
    end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", word_valid); end
  endtask

  // ch1 word pending (rr moves to 2), ch0 and ch2 full behind it: rr order must serve ch2 before ch0.
  task automatic test_overflow;
    word_ready = 1'b0;
    q.delete();
    send_word(2'd1, 8'h11);
    send_word(2'd0, 8'h5A);
    send_word(2'd2, 8'hC3);
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_before got %b exp 0000", overflow); end
    send(2'd0, 1'b1, 1'b0);
    checks++; if (overflow !== EXP_OVF) begin errors++; $display("FAIL ovf_set got %b exp %b", overflow, EXP_OVF); end
    checks++; if (word_ch !== 2'd1 || word_data !== 8'h11) begin errors++; $display("FAIL ovf_pending got %0d/%h exp 1/11", word_ch, word_data); end
    word_ready = 1'b1;
    idle(4);
    checks++; if (q.size() !== 3) begin errors++; $display("FAIL ovf_count got %0d exp 3", q.size()); end
    if (q.size() == 3) begin
      checks++; if (q[0].ch !== 2'd1 || q[0].data !== 8'h11) begin errors++; $display("FAIL ovf_w0 got %0d/%h exp 1/11", q[0].ch, q[0].data); end
      checks++; if (q[1].ch !== 2'd2 || q[1].data !== 8'hC3) begin errors++; $display("FAIL ovf_w1 got %0d/%h exp 2/c3", q[1].ch, q[1].data); end
      checks++; if (q[2].ch !== 2'd0 || q[2].data !== 8'h5A) begin errors++; $display("FAIL ovf_w2 got %0d/%h exp 0/5a", q[2].ch, q[2].data); end
    end
    checks++; if (overflow !== EXP_OVF) begin errors++; $display("FAIL ovf_sticky got %b exp %b", overflow, EXP_OVF); end
  endtask

  task automatic test_same_cycle_unload;
    logic [6:0] rest;
    rest = 7'b100_0000;
    word_ready = 1'b1;
    q.delete();
    send_word(2'd2, 8'h96);
    send(2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send(2'd2, rest[i], 1'b0);
    idle(3);
    checks++; if (q.size() !== 2) begin errors++; $display("FAIL same_count got %0d exp 2", q.size()); end
    if (q.size() == 2) begin
      checks++; if (q[0].ch !== 2'd2 || q[0].data !== 8'h96) begin errors++; $display("FAIL same_w0 got %0d/%h exp 2/96", q[0].ch, q[0].data); end
      checks++; if (q[1].ch !== 2'd2 || q[1].data !== 8'h81) begin errors++; $display("FAIL same_w1 got %0d/%h exp 2/81", q[1].ch, q[1].data); end
    end
  endtask

  task automatic test_async_reset;
    word_ready = 1'b0;
    q.delete();
    send_word(2'd3, 8'hE7);
    for (int i = 0; i < 3; i++) send(2'd0, 1'b1, 1'b0);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got %b exp 1", word_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", word_valid); end
    checks++; if (word_data !== 8'h00) begin errors++; $display("FAIL arst_data got %h exp 00", word_data); end
    checks++; if (word_ch !== 2'd0) begin errors++; $display("FAIL arst_ch got %0d exp 0", word_ch); end
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL arst_ovf got %b exp 0000", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    q.delete();
    send_word(2'd0, 8'h6B);
    idle(3);
    checks++; if (q.size() !== 1) begin errors++; $display("FAIL arst_count got %0d exp 1", q.size()); end
    if (q.size() == 1) begin
      checks++; if (q[0].ch !== 2'd0 || q[0].data !== 8'h6B) begin errors++; $display("FAIL arst_fresh got %0d/%h exp 0/6b", q[0].ch, q[0].data); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_backpressure();
    test_overflow();
    test_same_cycle_unload();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
